fft_peak_detect: RTL and testbench
==================================

// Module: fft_peak_detect
// PURPOSE
//  Scans one FFT output frame (N complex bins, one per en_comp strobe) and finds the bin with the largest
//  approximate power, |Re|^2+|Im|^2, computed on the top MAG_BITS of each component.
//  Reports the winning bin index in binary and as 4 BCD digits, and holds it until the next frame.
//  Sits between the FFT core output and the 7-segment display driver; peak_bcd drives the digits directly.
// PARAMETERS
//  bit_width  34  width of signed Re_in/Im_in from the FFT core
//  N          32  bins per frame (N <= 9999)
//  SIZE       5   log2(N), width of binary bin index
//  MAG_BITS   8   top bits of each component used for power (signed)
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  en_FFT      in   1              frame start strobe; clears scan state
//  done_all    in   1              FFT core finished/aborted; ends scan early
//  en_comp     in   1              Re_in/Im_in valid this cycle (one bin)
//  Re_in       in   bit_width      signed real part of current bin
//  Im_in       in   bit_width      signed imaginary part of current bin
//  peak_idx    out  SIZE           binary index of peak bin (0..N-1)
//  peak_bcd    out  16             peak index as BCD {d3,d2,d1,d0}, d0 = units
//  peak_mag    out  2*MAG_BITS+1   power of peak bin, unsigned
//  peak_valid  out  1              1-cycle pulse: new result on outputs
//  busy        out  1              high while in SCAN or DRAIN
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters and running max 0.
//  FSM: IDLE -(en_FFT)-> SCAN -(N-th en_comp accepted)-> DRAIN -(2 cycles)-> IDLE (peak_valid pulse on exit).
//   en_FFT in any state: restart. Clear bin counter, BCD counter, running max and pipeline; go to SCAN.
//   en_FFT wins over en_comp in the same cycle; that sample is discarded.
//   done_all in SCAN before N samples: go IDLE, no peak_valid, outputs keep the previous result.
//   en_comp in IDLE or DRAIN is ignored.
//  Sample path: re8/im8 = top MAG_BITS of Re_in/Im_in, signed.
//   Stage 1 (edge sampling en_comp): register p = re8*re8 + im8*im8, unsigned 2*MAG_BITS+1 bits,
//   together with bin index and BCD count.
//   Stage 2 (next edge): if p > run_max (strict), update run_max/run_idx/run_bcd. Ties keep the lowest index.
//   First sample of a frame always loads (run_max cleared to 0, bin 0 wins with p=0 if all zero).
//  Counters: bin index increments per accepted sample, 0..N-1.
//   BCD counter increments in lockstep: d0 rolls 9->0 and carries to d1, and so on; d3 9->0 wraps.
//  Latency: peak_idx/peak_bcd/peak_mag update, and peak_valid goes high for exactly 1 cycle,
//   on the 2nd rising edge after the edge that samples the N-th en_comp.
//   Outputs are held stable between pulses (not updated during a scan).
//  Full-scale: re8=im8=-2^(MAG_BITS-1) gives p=2^(2*MAG_BITS-1) with no overflow.
//  busy = (state != IDLE), registered.
// TESTING
//  1. Reset, en_FFT, 32 bins with re8=im8=0x10 except bin 5 re8=0x40, im8=0 -> peak_idx=5, peak_bcd=16'h0005,
//     peak_mag=4096, peak_valid 1 cycle, 2 clocks after 32nd en_comp.
//  2. Max at bin 31 (re8=0x80, im8=0x80) -> peak_idx=31, peak_bcd=16'h0031, peak_mag=32768 (no overflow).
//  3. Equal max power at bins 3 and 20 -> peak_idx=3; en_comp gaps of 0..5 cycles give the same result.
//  4. done_all after 10 samples -> no peak_valid, busy falls, outputs keep result of test 2.
//  5. en_FFT after 17 samples, then full new frame with peak at bin 9 -> peak_idx=9, peak_bcd=16'h0009.
//     en_FFT+en_comp in the same cycle drops that sample.
//  6. rst_n low mid-scan -> all outputs 0 immediately. Next frame counts from bin 0.

Source files
------------

// File: rtl/fft_peak_detect.sv
// Peak-power bin finder for one FFT output frame.
// Reports the winning bin as binary and 4-digit BCD, held until the next frame.
module fft_peak_detect #(
    parameter int bit_width = 34,
    parameter int N         = 32,
    parameter int SIZE      = 5,
    parameter int MAG_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_FFT,
    input  logic                  done_all,
    input  logic                  en_comp,
    input  logic [bit_width-1:0]  Re_in,
    input  logic [bit_width-1:0]  Im_in,
    output logic [SIZE-1:0]       peak_idx,
    output logic [15:0]           peak_bcd,
    output logic [2*MAG_BITS:0]   peak_mag,
    output logic                  peak_valid,
    output logic                  busy
);

    localparam int PW = 2 * MAG_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            drain_cnt_q, drain_cnt_d;
    logic [SIZE-1:0] bin_cnt_q, bin_cnt_d;
    logic [15:0]     bcd_cnt_q, bcd_cnt_d;

    logic            s1_valid_q, s1_valid_d;
    logic [PW-1:0]   s1_p_q, s1_p_d;
    logic [SIZE-1:0] s1_idx_q, s1_idx_d;
    logic [15:0]     s1_bcd_q, s1_bcd_d;

    logic            run_valid_q, run_valid_d;
    logic [PW-1:0]   run_max_q, run_max_d;
    logic [SIZE-1:0] run_idx_q, run_idx_d;
    logic [15:0]     run_bcd_q, run_bcd_d;

    logic [SIZE-1:0] peak_idx_q, peak_idx_d;
    logic [15:0]     peak_bcd_q, peak_bcd_d;
    logic [PW-1:0]   peak_mag_q, peak_mag_d;
    logic            peak_valid_q, peak_valid_d;
    logic            busy_q, busy_d;

    logic signed [MAG_BITS-1:0]   re8, im8;
    logic signed [2*MAG_BITS-1:0] re_sq, im_sq;
    logic [PW-1:0]                pwr;
    logic                         unused_lsbs;

    // Squares of MAG_BITS signed values are never negative and fit 2*MAG_BITS bits.
    assign re8   = Re_in[bit_width-1 -: MAG_BITS];
    assign im8   = Im_in[bit_width-1 -: MAG_BITS];
    assign re_sq = re8 * re8;
    assign im_sq = im8 * im8;
    assign pwr   = {1'b0, re_sq} + {1'b0, im_sq};

    assign unused_lsbs = ^{Re_in[bit_width-MAG_BITS-1:0],
                           Im_in[bit_width-MAG_BITS-1:0]};

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        bin_cnt_d    = bin_cnt_q;
        bcd_cnt_d    = bcd_cnt_q;
        s1_valid_d   = 1'b0;
        s1_p_d       = s1_p_q;
        s1_idx_d     = s1_idx_q;
        s1_bcd_d     = s1_bcd_q;
        run_valid_d  = run_valid_q;
        run_max_d    = run_max_q;
        run_idx_d    = run_idx_q;
        run_bcd_d    = run_bcd_q;
        peak_idx_d   = peak_idx_q;
        peak_bcd_d   = peak_bcd_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = 1'b0;

        // Strict compare keeps the earliest bin on ties.
        if (s1_valid_q && (!run_valid_q || s1_p_q > run_max_q)) begin
            run_valid_d = 1'b1;
            run_max_d   = s1_p_q;
            run_idx_d   = s1_idx_q;
            run_bcd_d   = s1_bcd_q;
        end

        if (en_FFT) begin
            state_d     = SCAN;
            drain_cnt_d = 1'b0;
            bin_cnt_d   = '0;
            bcd_cnt_d   = '0;
            run_valid_d = 1'b0;
            run_max_d   = '0;
            run_idx_d   = '0;
            run_bcd_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                SCAN: begin
                    if (done_all) begin
                        state_d = IDLE;
                    end else if (en_comp) begin
                        s1_valid_d = 1'b1;
                        s1_p_d     = pwr;
                        s1_idx_d   = bin_cnt_q;
                        s1_bcd_d   = bcd_cnt_q;
                        bin_cnt_d  = bin_cnt_q + 1'b1;
                        bcd_cnt_d  = bcd_inc(bcd_cnt_q);
                        if (bin_cnt_q == SIZE'(N - 1)) begin
                            state_d     = DRAIN;
                            drain_cnt_d = 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_d = 1'b1;
                    if (drain_cnt_q) begin
                        state_d      = IDLE;
                        peak_idx_d   = run_idx_q;
                        peak_bcd_d   = run_bcd_q;
                        peak_mag_d   = run_max_q;
                        peak_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drain_cnt_q  <= 1'b0;
            bin_cnt_q    <= '0;
            bcd_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_p_q       <= '0;
            s1_idx_q     <= '0;
            s1_bcd_q     <= '0;
            run_valid_q  <= 1'b0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
            run_bcd_q    <= '0;
            peak_idx_q   <= '0;
            peak_bcd_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            bin_cnt_q    <= bin_cnt_d;
            bcd_cnt_q    <= bcd_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_p_q       <= s1_p_d;
            s1_idx_q     <= s1_idx_d;
            s1_bcd_q     <= s1_bcd_d;
            run_valid_q  <= run_valid_d;
            run_max_q    <= run_max_d;
            run_idx_q    <= run_idx_d;
            run_bcd_q    <= run_bcd_d;
            peak_idx_q   <= peak_idx_d;
            peak_bcd_q   <= peak_bcd_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign peak_idx   = peak_idx_q;
    assign peak_bcd   = peak_bcd_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: directed frames, monitor checks each peak_valid pulse.
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_FFT, done_all, en_comp;
    logic [33:0] Re_in, Im_in;
    logic [4:0]  peak_idx;
    logic [15:0] peak_bcd;
    logic [16:0] peak_mag;
    logic        peak_valid, busy;

    fft_peak_detect dut (
        .clk(clk), .rst_n(rst_n), .en_FFT(en_FFT), .done_all(done_all),
        .en_comp(en_comp), .Re_in(Re_in), .Im_in(Im_in),
        .peak_idx(peak_idx), .peak_bcd(peak_bcd), .peak_mag(peak_mag),
        .peak_valid(peak_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] bcd;
        logic [16:0] mag;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] re_v[32];
    logic [7:0] im_v[32];
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (peak_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL pulse_width: peak_valid high 2 cycles at cyc %0d", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: idx %0d bcd %h mag %0d, none required", peak_idx, peak_bcd, peak_mag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (peak_idx !== e.idx || peak_bcd !== e.bcd || peak_mag !== e.mag || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL peak_result: got idx %0d bcd %h mag %0d cyc %0d, required idx %0d bcd %h mag %0d cyc %0d",
                             peak_idx, peak_bcd, peak_mag, cyc, e.idx, e.bcd, e.mag, e.cyc);
                end
            end
        end
        prev_valid <= peak_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] re, input logic [7:0] im);
        for (int i = 0; i < 32; i++) begin
            re_v[i] = re;
            im_v[i] = im;
        end
    endtask

    task automatic start_frame();
        en_FFT = 1'b1;
        @(posedge clk); #1;
        en_FFT = 1'b0;
    endtask

    task automatic drive_bin(input int i, input int gap);
        Re_in   = {re_v[i], 26'h2AAAAAA};
        Im_in   = {im_v[i], 26'h1555555};
        en_comp = 1'b1;
        @(posedge clk); #1;
        en_comp = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int gmode, input logic [4:0] eidx,
                              input logic [15:0] ebcd, input logic [16:0] emag);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                e.idx = eidx;
                e.bcd = ebcd;
                e.mag = emag;
                e.cyc = cyc + 3;
                sb.push_back(e);
            end
            drive_bin(i, (gmode != 0) ? (i % 6) : 0);
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en_FFT = 1'b0; done_all = 1'b0; en_comp = 1'b0;
        Re_in = '0; Im_in = '0;
        #1;
        chk("reset_idx", int'(peak_idx), 0);
        chk("reset_bcd", int'(peak_bcd), 0);
        chk("reset_mag", int'(peak_mag), 0);
        chk("reset_busy", int'(busy), 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Peak at bin 5
        start_frame();
        chk("busy_scan", int'(busy), 1);
        fill(8'h10, 8'h10);
        re_v[5] = 8'h40; im_v[5] = 8'h00;
        send_frame(0, 5'd5, 16'h0005, 17'd4096);
        chk("busy_idle", int'(busy), 0);

        // Full-scale at bin 31
        start_frame();
        fill(8'h10, 8'h10);
        re_v[31] = 8'h80; im_v[31] = 8'h80;
        send_frame(0, 5'd31, 16'h0031, 17'd32768);

        // Abort after 10 samples
        start_frame();
        fill(8'h7F, 8'h7F);
        for (int i = 0; i < 10; i++) drive_bin(i, 0);
        done_all = 1'b1;
        @(posedge clk); #1;
        done_all = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("abort_hold_idx", int'(peak_idx), 31);
        chk("abort_hold_bcd", int'(peak_bcd), 16'h0031);
        chk("abort_hold_mag", int'(peak_mag), 32768);

        // Ties at bins 3 and 20, no gaps then varied gaps
        for (int g = 0; g < 2; g++) begin
            start_frame();
            fill(8'h10, 8'h10);
            re_v[3]  = 8'h30; im_v[3]  = 8'h30;
            re_v[20] = 8'hD0; im_v[20] = 8'h30;
            send_frame(g, 5'd3, 16'h0003, 17'd4608);
        end

        // Restart after 17 samples; colliding en_comp sample is dropped
        start_frame();
        fill(8'h10, 8'h10);
        re_v[9] = 8'h50; im_v[9] = 8'h00;
        for (int i = 0; i < 17; i++) drive_bin(i, 0);
        en_FFT  = 1'b1;
        en_comp = 1'b1;
        Re_in   = {8'h7F, 26'h0};
        Im_in   = {8'h7F, 26'h0};
        @(posedge clk); #1;
        en_FFT  = 1'b0;
        en_comp = 1'b0;
        send_frame(0, 5'd9, 16'h0009, 17'd6400);

        // All-zero frame: bin 0 wins
        start_frame();
        fill(8'h00, 8'h00);
        send_frame(1, 5'd0, 16'h0000, 17'd0);

        // Peak at bin 10 crosses a BCD digit
        start_frame();
        fill(8'h10, 8'h00);
        re_v[10] = 8'h20; im_v[10] = 8'h20;
        send_frame(0, 5'd10, 16'h0010, 17'd2048);

        // Async reset mid-scan
        start_frame();
        fill(8'h10, 8'h10);
        for (int i = 0; i < 12; i++) drive_bin(i, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_idx", int'(peak_idx), 0);
        chk("rst_mid_bcd", int'(peak_bcd), 0);
        chk("rst_mid_mag", int'(peak_mag), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_valid", int'(peak_valid), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        start_frame();
        re_v[7] = 8'hC0; im_v[7] = 8'h00;
        send_frame(0, 5'd7, 16'h0007, 17'd4096);

        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
